mips_top: RTL and testbench

MIPS_TOP -- requirements
Module: mips_top

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_if.sv | 10 +
 rtl/mips_alu.sv | 31 +++
 rtl/mips_control.sv | 87 ++++++++
 rtl/mips_mem.sv | 34 +++
 rtl/mips_regfile.sv | 24 ++
 rtl/mips_top.sv | 108 ++++++++++
 tb/tb_mips_top.sv | 331 +++++++++++++++++++++++++++++++++
 8 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: instruction field positions,
// opcode/funct encodings, ALU operation enum and the decoded control bundle.
package mips_pkg;

  localparam int XLEN = 32;

  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int IMM_HI = 15, IMM_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;     // write rd instead of rt
    logic    alu_src;     // ALU B operand is the extended immediate
    logic    ext_zero;    // zero-extend rather than sign-extend the immediate
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_write;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    link;        // jal: write PC+4 into $31
    logic    jump_reg;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_if.sv
// Data-memory bus between the core datapath and the internal data RAM.
interface mips_if #(parameter int AW = 10);
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          we;

  modport master (output idx, wdata, we, input rdata);
  modport slave  (input idx, wdata, we, output rdata);
endinterface

// File: rtl/mips_alu.sv
// 32-bit ALU; arithmetic wraps, no overflow detection. zero feeds branch decisions.
module mips_alu import mips_pkg::*; (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_control.sv
// Main decoder: instruction op/funct to the control bundle; also classifies the
// instruction format (exactly one of R/I/J is asserted).
module mips_control import mips_pkg::*; (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  logic is_r_type_top;
  logic is_i_type_top;
  logic is_j_type_top;

  assign is_r_type_top = (op == OP_RTYPE);
  assign is_j_type_top = (op == OP_J) || (op == OP_JAL);
  assign is_i_type_top = !is_r_type_top && !is_j_type_top;

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    if (is_r_type_top) begin
      ctrl.reg_dst   = 1'b1;
      ctrl.reg_write = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
        FN_AND:          ctrl.alu_op = ALU_AND;
        FN_OR:           ctrl.alu_op = ALU_OR;
        FN_XOR:          ctrl.alu_op = ALU_XOR;
        FN_NOR:          ctrl.alu_op = ALU_NOR;
        FN_SLT:          ctrl.alu_op = ALU_SLT;
        FN_SLTU:         ctrl.alu_op = ALU_SLTU;
        FN_SLL:          ctrl.alu_op = ALU_SLL;
        FN_SRL:          ctrl.alu_op = ALU_SRL;
        FN_JR: begin
          ctrl.reg_write = 1'b0;
          ctrl.jump_reg  = 1'b1;
        end
        FN_SYSCALL:      ctrl.reg_write = 1'b0;
        default:         ctrl.reg_write = 1'b0;
      endcase
    end else if (is_j_type_top) begin
      ctrl.jump      = 1'b1;
      ctrl.link      = (op == OP_JAL);
      ctrl.reg_write = (op == OP_JAL);
    end else begin
      // Unrecognised opcodes fall through with every enable low.
      case (op)
        OP_ADDI, OP_ADDIU: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_SLTI: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT;
        end
        OP_ANDI: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_zero = 1'b1;
          ctrl.alu_op = ALU_AND;
        end
        OP_ORI: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_zero = 1'b1;
          ctrl.alu_op = ALU_OR;
        end
        OP_XORI: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_zero = 1'b1;
          ctrl.alu_op = ALU_XOR;
        end
        OP_LUI: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.ext_zero = 1'b1;
          ctrl.alu_op = ALU_LUI;
        end
        OP_LW: begin
          ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch_eq = 1'b1; ctrl.alu_op = ALU_SUB;
        end
        OP_BNE: begin
          ctrl.branch_ne = 1'b1; ctrl.alu_op = ALU_SUB;
        end
        default: ctrl.reg_write = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_mem.sv
// Internal word memories. Instruction memory contents come from an external image
// loaded into mem; data memory is written synchronously over the data bus.
module mips_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:WORDS-1];

  assign rdata = mem[idx];

endmodule

module mips_dmem #(
  parameter int WORDS = 1024
) (
  input logic   clk,
  mips_if.slave bus
);

  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.idx] <= bus.wdata;
    end
  end

  assign bus.rdata = mem[bus.idx];

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 register file: two combinational reads, one synchronous write; $0 is hardwired zero.
module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk) begin
    if (we && (wr_addr != 5'd0)) begin
      reg_file[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'h0 : reg_file[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'h0 : reg_file[rt_addr];

endmodule

// File: rtl/mips_top.sv
// Single-cycle 32-bit MIPS core: fetch, decode, execute and retire one instruction per clock.
module mips_top import mips_pkg::*; #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input logic clk,
  input logic reset_n
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] address, address_next, pc_plus4, instruction;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, write_reg;
  logic [15:0] imm;
  logic [31:0] imm_ext, branch_target, jump_target;
  logic [31:0] rs_data, rt_data, alu_b, alu_result, memtoreg_mux_output;
  logic        alu_zero, regwrite, memwrite, branch_taken;
  ctrl_t       ctrl;

  mips_if #(.AW(DAW)) dmem_bus ();

  mips_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) instr_mem (
    .idx   (address[IAW+1:2]),
    .rdata (instruction)
  );

  assign op    = instruction[OP_HI:OP_LO];
  assign rs    = instruction[RS_HI:RS_LO];
  assign rt    = instruction[RT_HI:RT_LO];
  assign rd    = instruction[RD_HI:RD_LO];
  assign shamt = instruction[SH_HI:SH_LO];
  assign funct = instruction[5:0];
  assign imm   = instruction[IMM_HI:IMM_LO];

  mips_control control_test (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  // Nothing is written to registers or memory while the core is held in reset.
  assign regwrite = ctrl.reg_write & reset_n;
  assign memwrite = ctrl.mem_write & reset_n;

  assign write_reg = ctrl.link ? 5'd31 : (ctrl.reg_dst ? rd : rt);

  mips_regfile register_file (
    .clk     (clk),
    .we      (regwrite),
    .rs_addr (rs),
    .rt_addr (rt),
    .wr_addr (write_reg),
    .wr_data (memtoreg_mux_output),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  assign imm_ext = ctrl.ext_zero ? {16'h0000, imm} : sext16(imm);
  assign alu_b   = ctrl.alu_src ? imm_ext : rt_data;

  mips_alu alu (
    .a      (rs_data),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (ctrl.alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign dmem_bus.idx   = alu_result[DAW+1:2];
  assign dmem_bus.wdata = rt_data;
  assign dmem_bus.we    = memwrite;

  mips_dmem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk (clk),
    .bus (dmem_bus)
  );

  assign memtoreg_mux_output = ctrl.link       ? pc_plus4 :
                               ctrl.mem_to_reg ? dmem_bus.rdata : alu_result;

  assign pc_plus4      = address + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign branch_taken  = (ctrl.branch_eq & alu_zero) | (ctrl.branch_ne & ~alu_zero);

  always_comb begin
    address_next = pc_plus4;
    if (ctrl.jump_reg) begin
      address_next = rs_data;
    end else if (ctrl.jump) begin
      address_next = jump_target;
    end else if (branch_taken) begin
      address_next = branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address <= '0;
    end else begin
      address <= address_next;
    end
  end

endmodule

// File: tb/tb_mips_top.sv
// Directed-program bench for mips_top: loads small programs into the instruction
// memory, steps the core clock by clock and checks architectural state.
module tb_mips_top;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mips_top #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  // Observation bundle mirroring the core's data-memory traffic.
  mips_if #(.AW(10)) probe ();
  assign probe.we    = dut.memwrite;
  assign probe.idx   = dut.alu_result[11:2];
  assign probe.wdata = dut.rt_data;
  assign probe.rdata = dut.memtoreg_mux_output;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_imem();
    for (int k = 0; k < 1024; k++) dut.instr_mem.mem[k] = 32'h0;
  endtask

  task automatic put(input int k, input logic [31:0] w);
    dut.instr_mem.mem[k] = w;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_imem();
    put(0, enc_i(6'h08, 5'd0, 5'd2, 16'd10));
    put(1, 32'h0000000C);
    put(2, enc_j(6'h02, 26'd2));
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dut.address !== 32'h0) begin
      n_bad++; $display("FAIL reset_pc_async: got %h want %h", dut.address, 32'h0);
    end else $display("ok   reset_pc_async = %h", dut.address);
    step(2);
    n_cmp++;
    if (dut.address !== 32'h0) begin
      n_bad++; $display("FAIL reset_pc_held: got %h want %h", dut.address, 32'h0);
    end else $display("ok   reset_pc_held = %h", dut.address);
    n_cmp++;
    if (dut.regwrite !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_regwrite: got %b want 0", dut.regwrite);
    end else $display("ok   reset_no_regwrite");
  endtask

  task automatic test_addi_syscall();
    restart();
    step(1);
    n_cmp++;
    if (dut.register_file.reg_file[2] !== 32'h0000000A) begin
      n_bad++; $display("FAIL addi_r2: got %h want %h", dut.register_file.reg_file[2], 32'hA);
    end else $display("ok   addi_r2 = %h", dut.register_file.reg_file[2]);
    n_cmp++;
    if (dut.address !== 32'h4) begin
      n_bad++; $display("FAIL pc_after_addi: got %h want %h", dut.address, 32'h4);
    end else $display("ok   pc_after_addi = %h", dut.address);
    n_cmp++;
    if (dut.regwrite !== 1'b0 || dut.memwrite !== 1'b0) begin
      n_bad++; $display("FAIL syscall_writes: got rw=%b mw=%b want 0 0", dut.regwrite, dut.memwrite);
    end else $display("ok   syscall_writes none");
    n_cmp++;
    if (dut.control_test.is_r_type_top !== 1'b1 || dut.control_test.is_i_type_top !== 1'b0 ||
        dut.control_test.is_j_type_top !== 1'b0) begin
      n_bad++; $display("FAIL syscall_class: got r=%b i=%b j=%b want 1 0 0",
                        dut.control_test.is_r_type_top, dut.control_test.is_i_type_top,
                        dut.control_test.is_j_type_top);
    end else $display("ok   syscall_class r-type");
    step(1);
    n_cmp++;
    if (dut.address !== 32'h8) begin
      n_bad++; $display("FAIL pc_after_syscall: got %h want %h", dut.address, 32'h8);
    end else $display("ok   pc_after_syscall = %h", dut.address);
    n_cmp++;
    if (dut.register_file.reg_file[2] !== 32'h0000000A) begin
      n_bad++; $display("FAIL syscall_r2_kept: got %h want %h", dut.register_file.reg_file[2], 32'hA);
    end else $display("ok   syscall_r2_kept");
  endtask

  task automatic test_alu();
    int          ridx [19] = '{8, 9, 10, 11, 12, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 4, 5};
    logic [31:0] rexp [19] = '{32'h5, 32'h7, 32'hC, 32'hFFFFFFFE, 32'h1, 32'h5, 32'h7, 32'h2,
                               32'hFFFFFFF8, 32'h0, 32'h70, 32'hF, 32'h12345678, 32'h0000FFFE,
                               32'hFFFFFFFF, 32'h1, 32'hA, 32'h80000000, 32'hFFFFFFF9};
    clear_imem();
    put(0,  enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    put(1,  enc_i(6'h08, 5'd0, 5'd9, 16'd7));
    put(2,  enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h20));
    put(3,  enc_r(5'd8, 5'd9, 5'd11, 5'd0, 6'h22));
    put(4,  enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h2A));
    put(5,  enc_r(5'd8, 5'd9, 5'd14, 5'd0, 6'h24));
    put(6,  enc_r(5'd8, 5'd9, 5'd15, 5'd0, 6'h25));
    put(7,  enc_r(5'd8, 5'd9, 5'd16, 5'd0, 6'h26));
    put(8,  enc_r(5'd8, 5'd9, 5'd17, 5'd0, 6'h27));
    put(9,  enc_r(5'd11, 5'd8, 5'd18, 5'd0, 6'h2B));
    put(10, enc_r(5'd0, 5'd9, 5'd19, 5'd4, 6'h00));
    put(11, enc_r(5'd0, 5'd11, 5'd20, 5'd28, 6'h02));
    put(12, enc_i(6'h0F, 5'd0, 5'd21, 16'h1234));
    put(13, enc_i(6'h0D, 5'd21, 5'd21, 16'h5678));
    put(14, enc_i(6'h0C, 5'd11, 5'd22, 16'hFFFF));
    put(15, enc_i(6'h09, 5'd0, 5'd23, 16'hFFFF));
    put(16, enc_i(6'h0A, 5'd11, 5'd24, 16'h0000));
    put(17, enc_i(6'h0E, 5'd8, 5'd25, 16'h000F));
    put(18, enc_i(6'h0F, 5'd0, 5'd3, 16'h7FFF));
    put(19, enc_i(6'h0D, 5'd3, 5'd3, 16'hFFFF));
    put(20, enc_i(6'h08, 5'd3, 5'd4, 16'h0001));
    put(21, enc_r(5'd0, 5'd9, 5'd5, 5'd0, 6'h23));
    put(22, enc_j(6'h02, 26'd22));
    restart();
    n_cmp++;
    if (dut.control_test.is_i_type_top !== 1'b1 || dut.control_test.is_r_type_top !== 1'b0) begin
      n_bad++; $display("FAIL addi_class: got i=%b r=%b want 1 0",
                        dut.control_test.is_i_type_top, dut.control_test.is_r_type_top);
    end else $display("ok   addi_class i-type");
    step(23);
    for (int k = 0; k < 19; k++) begin
      n_cmp++;
      if (dut.register_file.reg_file[ridx[k]] !== rexp[k]) begin
        n_bad++; $display("FAIL alu_r%0d: got %h want %h", ridx[k], dut.register_file.reg_file[ridx[k]], rexp[k]);
      end else $display("ok   alu_r%0d = %h", ridx[k], rexp[k]);
    end
    n_cmp++;
    if (dut.address !== 32'h58) begin
      n_bad++; $display("FAIL alu_final_pc: got %h want %h", dut.address, 32'h58);
    end else $display("ok   alu_final_pc = %h", dut.address);
  endtask

  task automatic test_mem();
    clear_imem();
    put(0, enc_i(6'h08, 5'd0, 5'd9, 16'd7));
    put(1, enc_i(6'h2B, 5'd0, 5'd9, 16'd4));
    put(2, enc_i(6'h23, 5'd0, 5'd13, 16'd4));
    put(3, enc_i(6'h08, 5'd0, 5'd0, 16'd5));
    put(4, enc_r(5'd0, 5'd9, 5'd26, 5'd0, 6'h20));
    put(5, enc_j(6'h02, 26'd5));
    restart();
    step(1);
    n_cmp++;
    if (probe.we !== 1'b1 || probe.idx !== 10'd1 || probe.wdata !== 32'h7) begin
      n_bad++; $display("FAIL sw_bus: got we=%b idx=%0d wdata=%h want 1 1 00000007", probe.we, probe.idx, probe.wdata);
    end else $display("ok   sw_bus we=1 idx=1 wdata=%h", probe.wdata);
    n_cmp++;
    if (dut.regwrite !== 1'b0) begin
      n_bad++; $display("FAIL sw_no_regwrite: got %b want 0", dut.regwrite);
    end else $display("ok   sw_no_regwrite");
    step(1);
    n_cmp++;
    if (dut.data_mem.mem[1] !== 32'h7) begin
      n_bad++; $display("FAIL dmem1: got %h want %h", dut.data_mem.mem[1], 32'h7);
    end else $display("ok   dmem1 = %h", dut.data_mem.mem[1]);
    n_cmp++;
    if (probe.rdata !== 32'h7) begin
      n_bad++; $display("FAIL lw_wb_data: got %h want %h", probe.rdata, 32'h7);
    end else $display("ok   lw_wb_data = %h", probe.rdata);
    step(1);
    n_cmp++;
    if (dut.register_file.reg_file[13] !== 32'h7) begin
      n_bad++; $display("FAIL lw_r13: got %h want %h", dut.register_file.reg_file[13], 32'h7);
    end else $display("ok   lw_r13 = %h", dut.register_file.reg_file[13]);
    step(2);
    n_cmp++;
    if (dut.register_file.reg_file[26] !== 32'h7) begin
      n_bad++; $display("FAIL r0_stays_zero: got r26=%h want %h", dut.register_file.reg_file[26], 32'h7);
    end else $display("ok   r0_stays_zero (r26=%h)", dut.register_file.reg_file[26]);
  endtask

  task automatic test_branch();
    clear_imem();
    put(0,  enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    put(1,  enc_i(6'h08, 5'd0, 5'd9, 16'd7));
    put(8,  enc_i(6'h04, 5'd8, 5'd8, 16'd2));
    put(9,  enc_i(6'h05, 5'd8, 5'd8, 16'd7));
    put(10, enc_i(6'h04, 5'd8, 5'd9, 16'd1));
    put(11, enc_i(6'h05, 5'd8, 5'd9, 16'hFFFD));
    restart();
    step(8);
    n_cmp++;
    if (dut.address !== 32'h20) begin
      n_bad++; $display("FAIL reach_beq: got %h want %h", dut.address, 32'h20);
    end else $display("ok   reach_beq = %h", dut.address);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h2C) begin
      n_bad++; $display("FAIL beq_taken: got %h want %h", dut.address, 32'h2C);
    end else $display("ok   beq_taken = %h", dut.address);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h24) begin
      n_bad++; $display("FAIL bne_taken_back: got %h want %h", dut.address, 32'h24);
    end else $display("ok   bne_taken_back = %h", dut.address);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h28) begin
      n_bad++; $display("FAIL bne_equal_falls: got %h want %h", dut.address, 32'h28);
    end else $display("ok   bne_equal_falls = %h", dut.address);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h2C) begin
      n_bad++; $display("FAIL beq_unequal_falls: got %h want %h", dut.address, 32'h2C);
    end else $display("ok   beq_unequal_falls = %h", dut.address);
  endtask

  task automatic test_jump();
    clear_imem();
    put(4,  enc_j(6'h03, 26'h40));
    put(5,  enc_j(6'h02, 26'h0C));
    put(12, enc_j(6'h02, 26'h0C));
    put(64, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    restart();
    step(4);
    n_cmp++;
    if (dut.control_test.is_j_type_top !== 1'b1 || dut.control_test.is_i_type_top !== 1'b0) begin
      n_bad++; $display("FAIL jal_class: got j=%b i=%b want 1 0",
                        dut.control_test.is_j_type_top, dut.control_test.is_i_type_top);
    end else $display("ok   jal_class j-type");
    n_cmp++;
    if (dut.memtoreg_mux_output !== 32'h14) begin
      n_bad++; $display("FAIL jal_wb_data: got %h want %h", dut.memtoreg_mux_output, 32'h14);
    end else $display("ok   jal_wb_data = %h", dut.memtoreg_mux_output);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h100) begin
      n_bad++; $display("FAIL jal_target: got %h want %h", dut.address, 32'h100);
    end else $display("ok   jal_target = %h", dut.address);
    n_cmp++;
    if (dut.register_file.reg_file[31] !== 32'h14) begin
      n_bad++; $display("FAIL jal_r31: got %h want %h", dut.register_file.reg_file[31], 32'h14);
    end else $display("ok   jal_r31 = %h", dut.register_file.reg_file[31]);
    n_cmp++;
    if (dut.regwrite !== 1'b0) begin
      n_bad++; $display("FAIL jr_no_regwrite: got %b want 0", dut.regwrite);
    end else $display("ok   jr_no_regwrite");
    step(1);
    n_cmp++;
    if (dut.address !== 32'h14) begin
      n_bad++; $display("FAIL jr_target: got %h want %h", dut.address, 32'h14);
    end else $display("ok   jr_target = %h", dut.address);
    step(1);
    n_cmp++;
    if (dut.address !== 32'h30) begin
      n_bad++; $display("FAIL j_target: got %h want %h", dut.address, 32'h30);
    end else $display("ok   j_target = %h", dut.address);
  endtask

  task automatic test_reset_mid();
    clear_imem();
    put(0, enc_i(6'h08, 5'd0, 5'd6, 16'd40));
    put(1, enc_j(6'h02, 26'd1));
    restart();
    step(3);
    n_cmp++;
    if (dut.register_file.reg_file[6] !== 32'd40 || dut.address !== 32'h4) begin
      n_bad++; $display("FAIL pre_reset_state: got r6=%h pc=%h want 00000028 00000004",
                        dut.register_file.reg_file[6], dut.address);
    end else $display("ok   pre_reset_state r6=%h pc=%h", dut.register_file.reg_file[6], dut.address);
    put(0, enc_i(6'h08, 5'd6, 5'd6, 16'd1));
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dut.address !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset_pc_async: got %h want %h", dut.address, 32'h0);
    end else $display("ok   mid_reset_pc_async = %h", dut.address);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dut.register_file.reg_file[6] !== 32'd40 || dut.address !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset_hold: got r6=%h pc=%h want 00000028 00000000",
                        dut.register_file.reg_file[6], dut.address);
    end else $display("ok   mid_reset_hold r6=%h", dut.register_file.reg_file[6]);
    n_cmp++;
    if (dut.regwrite !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_regwrite: got %b want 0", dut.regwrite);
    end else $display("ok   mid_reset_regwrite gated");
    reset_n = 1'b1;
    step(1);
    n_cmp++;
    if (dut.register_file.reg_file[6] !== 32'd41 || dut.address !== 32'h4) begin
      n_bad++; $display("FAIL restart_imem0: got r6=%h pc=%h want 00000029 00000004",
                        dut.register_file.reg_file[6], dut.address);
    end else $display("ok   restart_imem0 r6=%h pc=%h", dut.register_file.reg_file[6], dut.address);
  endtask

  initial begin
    test_reset();
    test_addi_syscall();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
